nibble_serial_adder: RTL and testbench

//  Sequential front-end for the 4-bit carry look-ahead adder (a, b, cin -> sum, Cout).

---
 rtl/nibble_serial_adder.sv | 109 ++++++++++
 tb/tb_nibble_serial_adder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// Serial WIDTH-bit adder: feeds one nibble per cycle through an external 4-bit CLA,
// chaining the carry, with valid/ready handshakes on the operand and result sides.
module nibble_serial_adder #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             Cout,
    output logic [3:0]       cla_a,
    output logic [3:0]       cla_b,
    output logic             cla_cin,
    input  logic [3:0]       cla_sum,
    input  logic             cla_cout
);

    localparam int unsigned NIBBLES = WIDTH / 4;
    localparam int unsigned IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e             r_state;
    state_e             w_state_d;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;
    logic               r_cout;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W+1:0]   w_base;
    logic               w_accept;
    logic               w_run;
    logic               w_last;

    assign w_base   = {r_idx, 2'b00};
    assign w_run    = (r_state == StRun);
    assign w_accept = (r_state == StIdle) && in_valid;
    assign w_last   = (r_idx == LAST_IDX);

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  if (in_valid)  w_state_d = StRun;
            StRun:   if (w_last)    w_state_d = StDone;
            StDone:  if (out_ready) w_state_d = StIdle;
            default:                w_state_d = StIdle;
        endcase
    end

    // CLA is only driven while a nibble is in flight; zero otherwise.
    always_comb begin
        cla_a   = 4'h0;
        cla_b   = 4'h0;
        cla_cin = 1'b0;
        if (w_run) begin
            cla_a   = r_a[w_base +: 4];
            cla_b   = r_b[w_base +: 4];
            cla_cin = r_carry;
        end
    end

    assign in_ready  = rst_n && (r_state == StIdle);
    assign out_valid = (r_state == StDone);
    assign sum       = r_sum;
    assign Cout      = r_cout;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_d;
            if (w_accept) begin
                r_a     <= a;
                r_b     <= b;
                r_carry <= cin;
                r_idx   <= '0;
            end
            if (w_run) begin
                r_sum[w_base +: 4] <= cla_sum;
                r_carry            <= cla_cout;
                // idx parks on the last nibble; the next accept clears it.
                if (w_last) begin
                    r_cout <= cla_cout;
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder (WIDTH=16) with a behavioural 4-bit CLA closing the loop.
module tb_nibble_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] sum;
    logic        Cout;
    logic [3:0]  cla_a;
    logic [3:0]  cla_b;
    logic        cla_cin;
    logic [3:0]  cla_sum;
    logic        cla_cout;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    nibble_serial_adder #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .Cout      (Cout),
        .cla_a     (cla_a),
        .cla_b     (cla_b),
        .cla_cin   (cla_cin),
        .cla_sum   (cla_sum),
        .cla_cout  (cla_cout)
    );

    // 4-bit carry look-ahead adder
    logic [3:0] g, p;
    logic [4:0] c;
    assign g = cla_a & cla_b;
    assign p = cla_a ^ cla_b;
    assign c[0] = cla_cin;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);
    assign cla_sum  = p ^ c[3:0];
    assign cla_cout = c[4];

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] s;
        logic        c;
        int          stall;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One full transaction; returns the presented result. Stall cycles hold out_ready low in DONE.
    task automatic run_op(input logic [15:0] a_v, input logic [15:0] b_v, input logic cin_v,
                          input int stall, input bit noisy, input bit rand_rdy,
                          output logic [15:0] s_o, output logic c_o);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("accept_wait", {31'd0, in_ready}, 32'd1);
        a = a_v;
        b = b_v;
        cin = cin_v;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            if (noisy) begin
                check("busy_in_ready", {31'd0, in_ready}, 32'd0);
                in_valid = 1'($urandom);
                a = 16'($urandom);
                b = 16'($urandom);
                cin = 1'($urandom);
            end
            if (rand_rdy) out_ready = 1'($urandom);
            @(posedge clk); #1;
            n++;
        end
        // Four edges after the accepting edge: the fifth counting the accept itself.
        check("latency", n, 32'd4);
        in_valid = 1'b0;
        out_ready = 1'b0;
        s_o = sum;
        c_o = Cout;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_sum", {16'd0, sum}, {16'd0, s_o});
            check("hold_cout", {31'd0, Cout}, {31'd0, c_o});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("drop_valid", {31'd0, out_valid}, 32'd0);
        check("back_idle", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] s;
        logic        co;
        logic [16:0] exp;
        logic [15:0] ra, rb;
        logic        rc;

        vecs[0] = '{16'h00F2, 16'h00D6, 1'b1, 16'h01C9, 1'b0, 0};
        vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 0};
        vecs[2] = '{16'hAAAA, 16'h5555, 1'b0, 16'hFFFF, 1'b0, 1};
        vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 6};
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 0};
        vecs[5] = '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 2};
        vecs[6] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 0};
        vecs[7] = '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 6};

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_sum", {16'd0, sum}, 32'd0);
        check("rst_cout", {31'd0, Cout}, 32'd0);
        check("rst_cla_a", {28'd0, cla_a}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("idle_cla_cin", {31'd0, cla_cin}, 32'd0);

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].stall, 1'b0, 1'b0, s, co);
            check("vec_sum", {16'd0, s}, {16'd0, vecs[i].s});
            check("vec_cout", {31'd0, co}, {31'd0, vecs[i].c});
        end

        // Operand changes and in_valid toggling during RUN must not disturb the captured set.
        run_op(16'h3C5A, 16'h0FA7, 1'b1, 1, 1'b1, 1'b0, s, co);
        check("noisy_sum", {16'd0, s}, 32'h0000_4C02);
        check("noisy_cout", {31'd0, co}, 32'd0);

        // Reset after two RUN cycles: partial result discarded.
        a = 16'hFFFF;
        b = 16'h0001;
        cin = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("midop_not_done", {31'd0, out_valid}, 32'd0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_sum", {16'd0, sum}, 32'd0);
        check("midrst_cla_a", {28'd0, cla_a}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("midrst_no_valid", {31'd0, out_valid}, 32'd0);
        end
        run_op(16'h1234, 16'h4321, 1'b0, 0, 1'b0, 1'b0, s, co);
        check("after_rst_sum", {16'd0, s}, 32'h0000_5555);
        check("after_rst_cout", {31'd0, co}, 32'd0);

        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            exp = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
            run_op(ra, rb, rc, int'($urandom_range(0, 3)), 1'b0, 1'b1, s, co);
            check("rand_sum", {16'd0, s}, {16'd0, exp[15:0]});
            check("rand_cout", {31'd0, co}, {31'd0, exp[16]});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
